// File: rtl/insn_fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states and the
// {pc, word} entry carried through the prefetch FIFO.
package insn_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/insn_fetch_if.sv
// Instruction memory read port: single-outstanding request held until ack.
interface insn_fetch_if;
  import insn_fetch_pkg::*;

  logic [XLEN-1:0] addr;
  logic            read;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (output addr, read, input rdata, ack);
  modport slave  (input addr, read, output rdata, ack);

endinterface

// File: rtl/insn_fetch_fifo.sv
// Prefetch FIFO of {pc, word} entries; clear wins over same-cycle push/pop.
module fetch_fifo
  import insn_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch stage: private fetch PC, single-outstanding memory reads,
// prefetch FIFO feeding the decoder, flush/restart on redirect.
module insn_fetch
  import insn_fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd1,
  parameter logic [XLEN-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  insn_fetch_if.master     imem,
  output logic [XLEN-1:0]  word,
  output logic [XLEN-1:0]  word_pc,
  output logic             word_valid
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_next;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_addr_next;
  logic            outstanding;
  logic            room;
  logic            issue;
  logic            push;
  logic            pop;
  logic            clear;
  logic            empty;
  logic            full;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  assign outstanding = (state == ST_WAIT) || (state == ST_DRAIN);
  assign room        = !full && ((count + CW'(outstanding)) < CW'(DEPTH));
  assign issue       = (state == ST_REQ) && room && !redirect;

  // The in-flight address is latched at issue so a redirect cannot move it.
  assign imem.read = issue || outstanding;
  assign imem.addr = outstanding ? req_addr : fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_addr <= req_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_addr_next = req_addr;
    push          = 1'b0;
    clear         = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next = ST_REQ;
      end
      ST_REQ: begin
        if (redirect) begin
          clear         = 1'b1;
          fetch_pc_next = redirect_pc;
        end else if (issue) begin
          req_addr_next = fetch_pc;
          if (imem.ack) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc + PC_STEP;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          clear         = 1'b1;
          fetch_pc_next = redirect_pc;
          state_next    = imem.ack ? ST_REQ : ST_DRAIN;
        end else if (imem.ack) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + PC_STEP;
          state_next    = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          clear         = 1'b1;
          fetch_pc_next = redirect_pc;
        end
        if (imem.ack) begin
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign push_data = '{pc: imem.addr, word: imem.rdata};
  assign pop       = !empty && !stall && !clear;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign word_valid = !empty;
  assign word       = empty ? NOP_WORD : head.word;
  assign word_pc    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_insn_fetch.sv
// Directed bench for insn_fetch with a configurable-latency memory model.
module tb_insn_fetch;
  import insn_fetch_pkg::*;

  localparam logic [31:0] K = 32'hC0DE0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] word;
  logic [31:0] word_pc;
  logic        word_valid;
  logic        mem_en = 1'b1;
  logic        force_ack = 1'b0;
  int          mem_lat = 0;
  int          wait_cnt;
  int          checks = 0;
  int          passes = 0;

  insn_fetch_if imem_bus ();

  insn_fetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0),
    .PC_STEP  (32'd1),
    .NOP_WORD (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus),
    .word        (word),
    .word_pc     (word_pc),
    .word_valid  (word_valid)
  );

  always #5 clk = ~clk;

  // Memory answers after mem_lat waiting cycles; data is the address xor K.
  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (imem_bus.read && !imem_bus.ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  assign imem_bus.ack   = force_ack | (mem_en & imem_bus.read & (wait_cnt >= mem_lat));
  assign imem_bus.rdata = imem_bus.addr ^ K;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    force_ack = 1'b0; mem_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++; if (imem_bus.read !== 1'b0) $display("[TB] FAIL reset_read got %b want 0", imem_bus.read); else passes++;
    checks++; if (imem_bus.addr !== 32'h0) $display("[TB] FAIL reset_addr got %h want 0", imem_bus.addr); else passes++;
    checks++; if (word !== 32'h0) $display("[TB] FAIL reset_word got %h want 0", word); else passes++;
    checks++; if (word_pc !== 32'h0) $display("[TB] FAIL reset_word_pc got %h want 0", word_pc); else passes++;
    checks++; if (word_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", word_valid); else passes++;
  endtask

  task automatic test_stream;
    mem_lat = 0;
    reset_dut();
    tick();
    checks++; if (imem_bus.read !== 1'b1 || imem_bus.addr !== 32'h0) $display("[TB] FAIL stream_first_req got %b/%h want 1/0", imem_bus.read, imem_bus.addr); else passes++;
    checks++; if (word_valid !== 1'b0) $display("[TB] FAIL stream_first_valid got %b want 0", word_valid); else passes++;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (word_valid !== 1'b1 || word_pc !== 32'(i)) $display("[TB] FAIL stream_word_pc got %b/%h want 1/%h", word_valid, word_pc, 32'(i)); else passes++;
      checks++; if (word !== (32'(i) ^ K)) $display("[TB] FAIL stream_word got %h want %h", word, 32'(i) ^ K); else passes++;
      checks++; if (imem_bus.addr !== 32'(i + 1)) $display("[TB] FAIL stream_addr got %h want %h", imem_bus.addr, 32'(i + 1)); else passes++;
    end
  endtask

  task automatic test_stall;
    mem_lat = 0;
    reset_dut();
    stall = 1'b1;
    repeat (10) tick();
    checks++; if (imem_bus.read !== 1'b0) $display("[TB] FAIL stall_read got %b want 0", imem_bus.read); else passes++;
    checks++; if (imem_bus.addr !== 32'h4) $display("[TB] FAIL stall_next_pc got %h want 4", imem_bus.addr); else passes++;
    checks++; if (word_valid !== 1'b1 || word_pc !== 32'h0) $display("[TB] FAIL stall_head got %b/%h want 1/0", word_valid, word_pc); else passes++;
    stall = 1'b0;
    #1;
    for (int j = 0; j < 5; j++) begin
      checks++; if (word_valid !== 1'b1 || word_pc !== 32'(j)) $display("[TB] FAIL unstall_pc got %b/%h want 1/%h", word_valid, word_pc, 32'(j)); else passes++;
      checks++; if (word !== (32'(j) ^ K)) $display("[TB] FAIL unstall_word got %h want %h", word, 32'(j) ^ K); else passes++;
      tick();
    end
  endtask

  task automatic test_latency;
    logic exp_valid;
    int   w;
    mem_lat = 3;
    reset_dut();
    tick();
    for (int c = 0; c < 16; c++) begin
      w = c / 4;
      exp_valid = (c % 4 == 0) && (c > 0);
      checks++; if (imem_bus.read !== 1'b1 || imem_bus.addr !== 32'(w)) $display("[TB] FAIL lat_req got %b/%h want 1/%h", imem_bus.read, imem_bus.addr, 32'(w)); else passes++;
      checks++; if (word_valid !== exp_valid) $display("[TB] FAIL lat_valid got %b want %b", word_valid, exp_valid); else passes++;
      if (exp_valid) begin
        checks++; if (word_pc !== 32'(w - 1) || word !== (32'(w - 1) ^ K)) $display("[TB] FAIL lat_word got %h/%h want %h/%h", word_pc, word, 32'(w - 1), 32'(w - 1) ^ K); else passes++;
      end else begin
        checks++; if (word !== 32'h0) $display("[TB] FAIL lat_bubble got %h want 0", word); else passes++;
      end
      tick();
    end
    mem_lat = 0;
  endtask

  task automatic test_redirect;
    mem_lat = 0;
    reset_dut();
    stall = 1'b1;
    repeat (3) tick();
    mem_en = 1'b0;
    tick();
    checks++; if (imem_bus.read !== 1'b1 || imem_bus.addr !== 32'h2) $display("[TB] FAIL redir_wait_req got %b/%h want 1/2", imem_bus.read, imem_bus.addr); else passes++;
    checks++; if (word_valid !== 1'b1 || word_pc !== 32'h0) $display("[TB] FAIL redir_buffered got %b/%h want 1/0", word_valid, word_pc); else passes++;
    redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    checks++; if (imem_bus.addr !== 32'h2) $display("[TB] FAIL redir_addr_stable got %h want 2", imem_bus.addr); else passes++;
    tick();
    redirect = 1'b0; mem_en = 1'b1;
    #1;
    checks++; if (word_valid !== 1'b0) $display("[TB] FAIL redir_flushed got %b want 0", word_valid); else passes++;
    checks++; if (imem_bus.read !== 1'b1 || imem_bus.addr !== 32'h2) $display("[TB] FAIL redir_drain_req got %b/%h want 1/2", imem_bus.read, imem_bus.addr); else passes++;
    tick();
    checks++; if (word_valid !== 1'b0) $display("[TB] FAIL redir_stale_dropped got %b want 0", word_valid); else passes++;
    checks++; if (imem_bus.read !== 1'b1 || imem_bus.addr !== 32'h100) $display("[TB] FAIL redir_new_req got %b/%h want 1/100", imem_bus.read, imem_bus.addr); else passes++;
    tick();
    checks++; if (word_valid !== 1'b1 || word_pc !== 32'h100 || word !== (32'h100 ^ K)) $display("[TB] FAIL redir_new_word got %b/%h/%h want 1/100/%h", word_valid, word_pc, word, 32'h100 ^ K); else passes++;
  endtask

  task automatic test_redirect_full;
    mem_lat = 0;
    reset_dut();
    stall = 1'b1;
    repeat (4) tick();
    mem_en = 1'b0;
    tick();
    checks++; if (imem_bus.read !== 1'b1 || imem_bus.addr !== 32'h3) $display("[TB] FAIL full_wait_req got %b/%h want 1/3", imem_bus.read, imem_bus.addr); else passes++;
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; mem_en = 1'b1;
    #1;
    checks++; if (word_valid !== 1'b1 || word_pc !== 32'h0) $display("[TB] FAIL full_head got %b/%h want 1/0", word_valid, word_pc); else passes++;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (word_valid !== 1'b0) $display("[TB] FAIL full_cleared got %b want 0", word_valid); else passes++;
    checks++; if (imem_bus.read !== 1'b1 || imem_bus.addr !== 32'h200) $display("[TB] FAIL full_next_req got %b/%h want 1/200", imem_bus.read, imem_bus.addr); else passes++;
    tick();
    checks++; if (word_valid !== 1'b1 || word_pc !== 32'h200) $display("[TB] FAIL full_new_word got %b/%h want 1/200", word_valid, word_pc); else passes++;
  endtask

  task automatic test_reset_mid;
    mem_lat = 0;
    reset_dut();
    repeat (3) tick();
    mem_en = 1'b0;
    tick();
    checks++; if (imem_bus.read !== 1'b1 || imem_bus.addr !== 32'h2) $display("[TB] FAIL rstmid_wait got %b/%h want 1/2", imem_bus.read, imem_bus.addr); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (imem_bus.read !== 1'b0 || imem_bus.addr !== 32'h0) $display("[TB] FAIL rstmid_req got %b/%h want 0/0", imem_bus.read, imem_bus.addr); else passes++;
    checks++; if (word_valid !== 1'b0 || word !== 32'h0 || word_pc !== 32'h0) $display("[TB] FAIL rstmid_out got %b/%h/%h want 0/0/0", word_valid, word, word_pc); else passes++;
    tick();
    rst = 1'b0; force_ack = 1'b1;
    #1;
    checks++; if (imem_bus.read !== 1'b0) $display("[TB] FAIL rstmid_idle_read got %b want 0", imem_bus.read); else passes++;
    tick();
    force_ack = 1'b0;
    #1;
    checks++; if (word_valid !== 1'b0) $display("[TB] FAIL rstmid_late_ack got %b want 0", word_valid); else passes++;
    checks++; if (imem_bus.read !== 1'b1 || imem_bus.addr !== 32'h0) $display("[TB] FAIL rstmid_restart got %b/%h want 1/0", imem_bus.read, imem_bus.addr); else passes++;
    mem_en = 1'b1;
  endtask

  task automatic test_wrap;
    mem_lat = 0;
    reset_dut();
    stall = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (imem_bus.read !== 1'b1 || imem_bus.addr !== 32'hFFFF_FFFF) $display("[TB] FAIL wrap_top_req got %b/%h want 1/ffffffff", imem_bus.read, imem_bus.addr); else passes++;
    tick();
    checks++; if (imem_bus.addr !== 32'h0) $display("[TB] FAIL wrap_addr got %h want 0", imem_bus.addr); else passes++;
    checks++; if (word_valid !== 1'b1 || word_pc !== 32'hFFFF_FFFF) $display("[TB] FAIL wrap_word_pc got %b/%h want 1/ffffffff", word_valid, word_pc); else passes++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_latency();
    test_redirect();
    test_redirect_full();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired, got %0d/%0d want completion", passes, checks);
    $fatal(1);
  end

endmodule
